// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the write-back exception/commit controller:
// CP0 register addresses ({rd, sel}), ExcCode values, FSM states and event encodings.
package exc_commit_ctrl_pkg;

    // CP0 register addresses as {rd[4:0], sel[2:0]}
    typedef enum logic [7:0] {
        Cp0BadVaddr = 8'h40,
        Cp0Count    = 8'h48,
        Cp0Compare  = 8'h58,
        Cp0Status   = 8'h60,
        Cp0Cause    = 8'h68,
        Cp0Epc      = 8'h70
    } cp0_addr_e;

    // ExcCode values reported to CP0 Cause
    typedef enum logic [4:0] {
        ExcInt  = 5'h00,
        ExcAdel = 5'h04,
        ExcAdes = 5'h05,
        ExcSys  = 5'h08,
        ExcBp   = 5'h09,
        ExcRi   = 5'h0a,
        ExcOv   = 5'h0c
    } exccode_e;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } state_e;

    // Where the redirect PC comes from when a trap commits
    typedef enum logic {
        TgtExEntry,
        TgtCp0
    } tgt_sel_e;

    // One-hot commit event; all zero when nothing special commits
    typedef struct packed {
        logic intr;
        logic exc;
        logic eret;
        logic mtc0;
    } ev_t;

    // Events that leave IDLE and end in a redirect
    function automatic logic ev_is_trap(ev_t ev);
        return ev.intr | ev.exc | ev.eret;
    endfunction

endpackage

// File: rtl/exc_prio_arb.sv
// Commit-time priority arbiter: interrupt > exception > ERET > MTC0.
import exc_commit_ctrl_pkg::*;

module exc_prio_arb (
    input  logic       commit_i,
    input  logic       has_int_i,
    input  logic       ex_i,
    input  logic [4:0] exccode_i,
    input  logic       eret_i,
    input  logic       mtc0_i,
    output ev_t        ev_o,
    output logic [4:0] exccode_o,
    output tgt_sel_e   tgt_sel_o
);

    // Pick the single highest-priority event of the committing instruction
    always_comb begin
        ev_o      = '0;
        exccode_o = ExcInt;
        tgt_sel_o = TgtExEntry;
        if (commit_i) begin
            if (has_int_i) begin
                ev_o.intr = 1'b1;
            end else if (ex_i) begin
                ev_o.exc  = 1'b1;
                exccode_o = exccode_i;
            end else if (eret_i) begin
                ev_o.eret = 1'b1;
                tgt_sel_o = TgtCp0;
            end else if (mtc0_i) begin
                ev_o.mtc0 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Write-back exception/commit controller: drives the CP0 write/event ports at commit,
// flushes the pipeline after a trap, then hands the redirect PC to IF via valid/ready.
import exc_commit_ctrl_pkg::*;

module exc_commit_ctrl #(
    parameter logic [31:0] EX_ENTRY     = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [7:0]  EPC_ADDR     = Cp0Epc
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic        ws_ex,
    input  logic [4:0]  ws_exccode,
    input  logic        ws_bd,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_eret,
    input  logic        ws_mtc0,
    input  logic [7:0]  ws_cp0_addr,
    input  logic [31:0] ws_cp0_wdata,
    input  logic        has_int,
    input  logic [31:0] cp0_rdata,
    output logic        mtc0_we,
    output logic [7:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        eret_flush,
    output logic        wb_ex,
    output logic [4:0]  wb_exccode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_BadVaddr,
    output logic        pipe_flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic            pipe_flush_q, redirect_valid_q;

    logic            commit;
    ev_t             ev;
    logic [4:0]      arb_exccode;
    tgt_sel_e        tgt_sel;

    // Gating with resetn keeps every CP0 strobe low while reset is asserted
    assign commit   = ws_valid & resetn & (state_q == StIdle);
    assign ws_ready = (state_q == StIdle);

    exc_prio_arb u_arb (
        .commit_i  (commit),
        .has_int_i (has_int),
        .ex_i      (ws_ex),
        .exccode_i (ws_exccode),
        .eret_i    (ws_eret),
        .mtc0_i    (ws_mtc0),
        .ev_o      (ev),
        .exccode_o (arb_exccode),
        .tgt_sel_o (tgt_sel)
    );

    // CP0 ports are combinational so CP0 captures them on the commit edge
    always_comb begin
        wb_ex       = ev.intr | ev.exc;
        wb_exccode  = arb_exccode;
        wb_bd       = wb_ex & ws_bd;
        wb_pc       = wb_ex ? ws_pc : 32'h0;
        wb_BadVaddr = wb_ex ? ws_badvaddr : 32'h0;
        eret_flush  = ev.eret;
        mtc0_we     = ev.mtc0;
        cp0_addr    = ev.eret ? EPC_ADDR : ws_cp0_addr;
        cp0_wdata   = ws_cp0_wdata;
    end

    // Next state, flush countdown and redirect target capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (ev_is_trap(ev)) begin
                    state_d       = StFlush;
                    cnt_d         = CntInit;
                    // ERET reads EPC in this cycle; CP0 forwards a same-address MTC0 from the
                    // previous cycle, so the freshest EPC is seen here
                    redirect_pc_d = (tgt_sel == TgtCp0) ? cp0_rdata : EX_ENTRY;
                end
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; flush/valid follow the next state so they are glitch-free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            redirect_pc_q    <= 32'h0;
            pipe_flush_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            pipe_flush_q     <= (state_d == StFlush);
            redirect_valid_q <= (state_d == StRedirect);
        end
    end

    assign pipe_flush     = pipe_flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: constant-expectation vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural reference model.
module tb_exc_commit_ctrl;

    localparam logic [31:0] ENTRY = 32'hBFC0_0380;
    localparam int          FLUSH = 2;
    localparam logic [7:0]  EPC   = 8'h70;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ws_valid = 0, ws_ex = 0, ws_bd = 0, ws_eret = 0, ws_mtc0 = 0, has_int = 0;
    logic [4:0]  ws_exccode = 0;
    logic [31:0] ws_pc = 0, ws_badvaddr = 0, ws_cp0_wdata = 0;
    logic [7:0]  ws_cp0_addr = 0;
    logic        redirect_ready = 0;
    logic [31:0] cp0_rdata;
    logic        ws_ready, mtc0_we, eret_flush, wb_ex, wb_bd, pipe_flush, redirect_valid;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata, wb_pc, wb_BadVaddr, redirect_pc;
    logic [4:0]  wb_exccode;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_flush = 0;
    bit          m_redir = 0;
    logic [31:0] m_tgt = 0;
    logic [31:0] m_epc = 0;

    // Environment CP0: EPC register written by MTC0 or by an exception
    logic [31:0] env_epc = 0;

    always #5 clk = ~clk;

    assign cp0_rdata = (cp0_addr == EPC) ? env_epc : 32'h1234_5678;

    always @(posedge clk) begin
        if (resetn) begin
            if (mtc0_we && cp0_addr == EPC) env_epc <= cp0_wdata;
            else if (wb_ex) env_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
        end
    end

    exc_commit_ctrl #(
        .EX_ENTRY     (ENTRY),
        .FLUSH_CYCLES (FLUSH),
        .EPC_ADDR     (EPC)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_valid       (ws_valid),
        .ws_ready       (ws_ready),
        .ws_ex          (ws_ex),
        .ws_exccode     (ws_exccode),
        .ws_bd          (ws_bd),
        .ws_pc          (ws_pc),
        .ws_badvaddr    (ws_badvaddr),
        .ws_eret        (ws_eret),
        .ws_mtc0        (ws_mtc0),
        .ws_cp0_addr    (ws_cp0_addr),
        .ws_cp0_wdata   (ws_cp0_wdata),
        .has_int        (has_int),
        .cp0_rdata      (cp0_rdata),
        .mtc0_we        (mtc0_we),
        .cp0_addr       (cp0_addr),
        .cp0_wdata      (cp0_wdata),
        .eret_flush     (eret_flush),
        .wb_ex          (wb_ex),
        .wb_exccode     (wb_exccode),
        .wb_bd          (wb_bd),
        .wb_pc          (wb_pc),
        .wb_BadVaddr    (wb_BadVaddr),
        .pipe_flush     (pipe_flush),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        valid, ex, bd, eret, mtc0, intr;
        logic [4:0]  code;
        logic [31:0] pc, bad;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        e_ex, e_bd, e_eret, e_mtc0;
        logic [4:0]  e_code;
        logic [31:0] e_pc, e_bad;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mkv(logic v, logic i, logic x, logic [4:0] c, logic b,
                                 logic [31:0] p, logic [31:0] bv, logic er, logic mt,
                                 logic [7:0] a, logic [31:0] wd,
                                 logic ee, logic [4:0] ec, logic eb, logic [31:0] ep,
                                 logic [31:0] ebv, logic eer, logic emt, logic [7:0] ea);
        vec_t r;
        r.valid = v; r.intr = i; r.ex = x; r.code = c; r.bd = b; r.pc = p; r.bad = bv;
        r.eret = er; r.mtc0 = mt; r.addr = a; r.wdata = wd;
        r.e_ex = ee; r.e_code = ec; r.e_bd = eb; r.e_pc = ep; r.e_bad = ebv;
        r.e_eret = eer; r.e_mtc0 = emt; r.e_addr = ea;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ws_valid = 0; ws_ex = 0; ws_bd = 0; ws_eret = 0; ws_mtc0 = 0; has_int = 0;
        ws_exccode = 0; ws_pc = 0; ws_badvaddr = 0; ws_cp0_addr = 0; ws_cp0_wdata = 0;
    endtask

    // Called shortly after a negedge; returns at the next negedge with the model reset
    task automatic do_reset();
        resetn = 0;
        #1;
        n_vec++;
        chk("rst.pipe_flush", {31'b0, pipe_flush}, 0);
        chk("rst.redirect_valid", {31'b0, redirect_valid}, 0);
        chk("rst.redirect_pc", redirect_pc, 0);
        m_flush = 0; m_redir = 0; m_tgt = 0;
        @(negedge clk);
        resetn = 1;
    endtask

    // One clock: check combinational outputs against the model, advance, check registers
    task automatic cycle(string tag);
        bit         idle, com, ex, er, mt;
        logic [4:0] code;
        logic [7:0] addr;
        idle = (m_flush == 0) && !m_redir;
        com  = ws_valid && idle;
        ex   = com && (has_int || ws_ex);
        code = (ex && !has_int) ? ws_exccode : 5'd0;
        er   = com && !ex && ws_eret;
        mt   = com && !ex && !er && ws_mtc0;
        addr = er ? EPC : ws_cp0_addr;
        #1;
        n_vec++;
        chk({tag, ".ws_ready"}, {31'b0, ws_ready}, {31'b0, idle});
        chk({tag, ".wb_ex"}, {31'b0, wb_ex}, {31'b0, ex});
        chk({tag, ".wb_exccode"}, {27'b0, wb_exccode}, {27'b0, code});
        chk({tag, ".wb_bd"}, {31'b0, wb_bd}, {31'b0, ex && ws_bd});
        chk({tag, ".wb_pc"}, wb_pc, ex ? ws_pc : 32'h0);
        chk({tag, ".wb_BadVaddr"}, wb_BadVaddr, ex ? ws_badvaddr : 32'h0);
        chk({tag, ".eret_flush"}, {31'b0, eret_flush}, {31'b0, er});
        chk({tag, ".mtc0_we"}, {31'b0, mtc0_we}, {31'b0, mt});
        chk({tag, ".cp0_addr"}, {24'b0, cp0_addr}, {24'b0, addr});
        chk({tag, ".cp0_wdata"}, cp0_wdata, ws_cp0_wdata);
        @(posedge clk);
        #1;
        if (ex || er) begin
            m_flush = FLUSH;
            m_tgt   = ex ? ENTRY : m_epc;
        end else if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) m_redir = 1;
        end else if (m_redir && redirect_ready) begin
            m_redir = 0;
        end
        if (mt && ws_cp0_addr == EPC) m_epc = ws_cp0_wdata;
        else if (ex) m_epc = ws_bd ? ws_pc - 32'd4 : ws_pc;
        chk({tag, ".pipe_flush"}, {31'b0, pipe_flush}, {31'b0, m_flush > 0});
        chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, m_redir});
        chk({tag, ".redirect_pc"}, redirect_pc, m_tgt);
        @(negedge clk);
    endtask

    task automatic wait_redirect(string tag);
        for (int i = 0; i < 10 && !redirect_valid; i++) cycle({tag, ".wait"});
        chk({tag, ".redirect_seen"}, {31'b0, redirect_valid}, 1);
    endtask

    initial begin
        int flush_cnt;
        //            v  i  x  code  bd pc            bad         er mt addr   wdata
        //            ex code  bd  pc            bad           er mt addr
        tbl[0] = mkv(1, 0, 1, 5'd8, 0, 32'hBFC0_1000, 32'h0, 0, 0, 8'h00, 32'h0,
                     1, 5'd8, 0, 32'hBFC0_1000, 32'h0, 0, 0, 8'h00);
        tbl[1] = mkv(1, 0, 1, 5'd4, 1, 32'h8000_0104, 32'h3, 0, 0, 8'h00, 32'h0,
                     1, 5'd4, 1, 32'h8000_0104, 32'h3, 0, 0, 8'h00);
        tbl[2] = mkv(1, 1, 1, 5'd12, 0, 32'h8000_0200, 32'h0, 0, 0, 8'h00, 32'h0,
                     1, 5'd0, 0, 32'h8000_0200, 32'h0, 0, 0, 8'h00);
        tbl[3] = mkv(1, 0, 0, 5'd0, 0, 32'h8000_0300, 32'h0, 1, 0, 8'h40, 32'h0,
                     0, 5'd0, 0, 32'h0, 32'h0, 1, 0, 8'h70);
        tbl[4] = mkv(1, 0, 0, 5'd0, 0, 32'h8000_0400, 32'h0, 0, 1, 8'h68, 32'h5,
                     0, 5'd0, 0, 32'h0, 32'h0, 0, 1, 8'h68);
        tbl[5] = mkv(0, 1, 1, 5'd10, 1, 32'h8000_0500, 32'h9, 0, 0, 8'h40, 32'h0,
                     0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 8'h40);
        tbl[6] = mkv(1, 0, 0, 5'd0, 0, 32'h8000_0600, 32'h0, 0, 0, 8'h00, 32'h0,
                     0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 8'h00);
        tbl[7] = mkv(1, 1, 0, 5'd0, 0, 32'h8000_0700, 32'h0, 1, 1, 8'h70, 32'h0,
                     1, 5'd0, 0, 32'h8000_0700, 32'h0, 0, 0, 8'h70);
        tbl[8] = mkv(1, 0, 1, 5'd10, 0, 32'h8000_0800, 32'h0, 0, 1, 8'h70, 32'h0,
                     1, 5'd10, 0, 32'h8000_0800, 32'h0, 0, 0, 8'h70);

        @(negedge clk);
        // Outputs while in reset, even with an instruction presented
        ws_valid = 1; ws_ex = 1; has_int = 1; ws_eret = 1; ws_mtc0 = 1;
        #1;
        n_vec++;
        chk("reset.wb_ex", {31'b0, wb_ex}, 0);
        chk("reset.eret_flush", {31'b0, eret_flush}, 0);
        chk("reset.mtc0_we", {31'b0, mtc0_we}, 0);
        chk("reset.pipe_flush", {31'b0, pipe_flush}, 0);
        chk("reset.redirect_valid", {31'b0, redirect_valid}, 0);
        chk("reset.redirect_pc", redirect_pc, 0);
        clear_inputs();
        @(negedge clk);
        resetn = 1;

        // Table: single-commit vectors from IDLE with constant expectations
        for (int k = 0; k < 9; k++) begin
            do_reset();
            ws_valid = tbl[k].valid; has_int = tbl[k].intr; ws_ex = tbl[k].ex;
            ws_exccode = tbl[k].code; ws_bd = tbl[k].bd; ws_pc = tbl[k].pc;
            ws_badvaddr = tbl[k].bad; ws_eret = tbl[k].eret; ws_mtc0 = tbl[k].mtc0;
            ws_cp0_addr = tbl[k].addr; ws_cp0_wdata = tbl[k].wdata;
            #1;
            n_vec++;
            chk($sformatf("tbl%0d.wb_ex", k), {31'b0, wb_ex}, {31'b0, tbl[k].e_ex});
            chk($sformatf("tbl%0d.wb_exccode", k), {27'b0, wb_exccode}, {27'b0, tbl[k].e_code});
            chk($sformatf("tbl%0d.wb_bd", k), {31'b0, wb_bd}, {31'b0, tbl[k].e_bd});
            chk($sformatf("tbl%0d.wb_pc", k), wb_pc, tbl[k].e_pc);
            chk($sformatf("tbl%0d.wb_BadVaddr", k), wb_BadVaddr, tbl[k].e_bad);
            chk($sformatf("tbl%0d.eret_flush", k), {31'b0, eret_flush}, {31'b0, tbl[k].e_eret});
            chk($sformatf("tbl%0d.mtc0_we", k), {31'b0, mtc0_we}, {31'b0, tbl[k].e_mtc0});
            chk($sformatf("tbl%0d.cp0_addr", k), {24'b0, cp0_addr}, {24'b0, tbl[k].e_addr});
            cycle($sformatf("tbl%0d", k));
            clear_inputs();
            redirect_ready = 1;
            for (int j = 0; j < 5; j++) cycle($sformatf("tbl%0d.drain", k));
            redirect_ready = 0;
        end

        // Syscall: one wb_ex pulse, two flush cycles, then redirect to the vector
        do_reset();
        ws_valid = 1; ws_ex = 1; ws_exccode = 5'd8; ws_pc = 32'hBFC0_1000;
        cycle("sys.commit");
        clear_inputs();
        flush_cnt = 0;
        for (int i = 0; i < 10 && !redirect_valid; i++) begin
            if (pipe_flush) flush_cnt++;
            cycle("sys.flush");
        end
        chk("sys.flush_cycles", flush_cnt, FLUSH);
        chk("sys.redirect_valid", {31'b0, redirect_valid}, 1);
        chk("sys.redirect_pc", redirect_pc, ENTRY);
        redirect_ready = 1;
        cycle("sys.handshake");
        chk("sys.back_idle", {31'b0, ws_ready}, 1);
        redirect_ready = 0;

        // MTC0 EPC followed directly by ERET: redirect to the freshly written EPC
        do_reset();
        ws_valid = 1; ws_mtc0 = 1; ws_cp0_addr = EPC; ws_cp0_wdata = 32'h8000_2000;
        cycle("mtc0");
        clear_inputs();
        ws_valid = 1; ws_eret = 1; ws_cp0_addr = 8'h60;
        #1;
        n_vec++;
        chk("eret.cp0_addr", {24'b0, cp0_addr}, {24'b0, EPC});
        chk("eret.eret_flush", {31'b0, eret_flush}, 1);
        cycle("eret");
        clear_inputs();
        redirect_ready = 1;
        wait_redirect("eret");
        chk("eret.redirect_pc", redirect_pc, 32'h8000_2000);
        cycle("eret.handshake");
        redirect_ready = 0;

        // Late redirect_ready with WB traffic and interrupts toggling meanwhile
        do_reset();
        ws_valid = 1; ws_ex = 1; ws_exccode = 5'd12; ws_pc = 32'h8000_0040;
        cycle("stall.commit");
        clear_inputs();
        wait_redirect("stall");
        for (int i = 0; i < 5; i++) begin
            ws_valid = i[0]; has_int = ~i[0]; ws_eret = 1; ws_mtc0 = 1; ws_ex = 1;
            cycle("stall.hold");
            chk("stall.redirect_pc", redirect_pc, ENTRY);
            chk("stall.ws_ready", {31'b0, ws_ready}, 0);
        end
        clear_inputs();
        has_int = 1;
        redirect_ready = 1;
        cycle("stall.handshake");
        ws_valid = 1;
        cycle("stall.int_after");
        clear_inputs();
        for (int j = 0; j < 5; j++) cycle("stall.drain");
        redirect_ready = 0;

        // Asynchronous reset in the middle of FLUSH
        do_reset();
        ws_valid = 1; ws_ex = 1; ws_exccode = 5'd9; ws_pc = 32'h8000_0080;
        cycle("rflush.commit");
        chk("rflush.in_flush", {31'b0, pipe_flush}, 1);
        #2;
        resetn = 0;
        ws_valid = 1; has_int = 1;
        #1;
        n_vec++;
        chk("rflush.pipe_flush", {31'b0, pipe_flush}, 0);
        chk("rflush.redirect_valid", {31'b0, redirect_valid}, 0);
        chk("rflush.redirect_pc", redirect_pc, 0);
        chk("rflush.wb_ex", {31'b0, wb_ex}, 0);
        m_flush = 0; m_redir = 0; m_tgt = 0;
        clear_inputs();
        @(negedge clk);
        resetn = 1;
        ws_valid = 1; ws_pc = 32'h8000_0090;
        cycle("rflush.plain");
        chk("rflush.no_flush", {31'b0, pipe_flush}, 0);
        clear_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ws_valid     = ($urandom_range(0, 9) < 7);
            has_int      = ($urandom_range(0, 9) == 0);
            ws_ex        = ($urandom_range(0, 9) == 0);
            ws_eret      = ($urandom_range(0, 9) == 0);
            ws_mtc0      = ($urandom_range(0, 4) == 0);
            ws_bd        = $urandom_range(0, 1);
            ws_exccode   = 5'($urandom_range(0, 31));
            ws_pc        = $urandom & 32'hFFFF_FFFC;
            ws_badvaddr  = $urandom;
            ws_cp0_addr  = $urandom_range(0, 1) ? EPC : 8'($urandom_range(0, 255));
            ws_cp0_wdata = $urandom;
            redirect_ready = ($urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
Write-back-stage exception/commit controller: the initiator side of the CP0 interface.
- Arbitrates interrupt, instruction exception, ERET and MTC0 at instruction commit.
- Drives the CP0 write/event strobes and address.
- Flushes the pipeline, then hands a redirect PC to IF with a valid/ready handshake.

Parameters:
EX_ENTRY, 32'hBFC0_0380, exception vector (BEV=1).
FLUSH_CYCLES, 2, cycles pipe_flush is held (min 1).
EPC_ADDR, 8'h70, CP0 address of EPC ({rd,sel}).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
ws_valid  in  1  WB holds an instruction
ws_ready  out  1  controller accepts commit (IDLE)
ws_ex  in  1  instruction raised exception
ws_exccode  in  5  its ExcCode
ws_bd  in  1  instruction in delay slot
ws_pc  in  32  instruction PC
ws_badvaddr  in  32  faulting address (AdEL/AdES)
ws_eret  in  1  instruction is ERET
ws_mtc0  in  1  instruction is MTC0
ws_cp0_addr  in  8  MTC0/MFC0 CP0 address
ws_cp0_wdata  in  32  MTC0 data
has_int  in  1  CP0 pending enabled interrupt
cp0_rdata  in  32  CP0 read data
mtc0_we, cp0_addr[8], cp0_wdata[32]  out  CP0 write port
eret_flush, wb_ex, wb_exccode[5], wb_bd, wb_pc[32], wb_BadVaddr[32]  out  CP0 event port
pipe_flush  out  1  kill IF..WB
redirect_valid  out  1  redirect_pc valid
redirect_ready  in  1  IF accepts redirect
redirect_pc  out  32  new fetch PC

Behaviour:
- commit = ws_valid & state==IDLE. ws_ready = (state==IDLE). CP0 port outputs are combinational from ws_* at commit; CP0 samples them on the same edge.
- Priority at commit:
  - 1. Interrupt (has_int): wb_ex=1, wb_exccode=5'h00; the instruction is not executed.
  - 2. ws_ex: wb_ex=1, wb_exccode=ws_exccode.
  - 3. ws_eret: eret_flush=1.
  - 4. ws_mtc0: mtc0_we=1.
- wb_bd, wb_pc and wb_BadVaddr pass ws_* whenever wb_ex=1; otherwise they are 0.
- mtc0_we is never asserted together with wb_ex or eret_flush.
- cp0_addr: EPC_ADDR during an ERET commit; else ws_cp0_addr. cp0_wdata = ws_cp0_wdata.
- Redirect target register:
  - Exception: loads EX_ENTRY.
  - ERET: loads cp0_rdata in the commit cycle. An MTC0 EPC committed in the preceding cycle is visible.
- FSM:
  - IDLE -> FLUSH on an exception or ERET commit. cnt <= FLUSH_CYCLES-1.
  - FLUSH: pipe_flush=1 (registered). cnt decrements each cycle; at cnt==0 -> REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc held stable. redirect_ready=1 -> IDLE on that edge.
  - A plain commit or MTC0 commit stays in IDLE.
- Outside IDLE:
  - ws_ready=0; WB contents are discarded.
  - has_int is ignored and no CP0 strobe fires.
  - An interrupt still pending is taken at the next commit after IDLE.
- redirect_ready may be asserted early or late. Wait is unbounded; redirect_valid does not drop before the handshake.
- Reset (any state, asynchronous): state=IDLE, cnt=0, pipe_flush=0, redirect_valid=0, redirect_pc=0. All CP0 strobes are 0 while resetn=0.
- ws_valid=0: all CP0 strobes are 0 regardless of has_int.

Decomposition:
- Shared header: CP0 address macros (STATUS/CAUSE/EPC/BADVADDR/COUNT/COMPARE), ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), FSM state encodings.
- Sub-module exc_prio_arb: combinational priority arbiter producing the event one-hot, exccode and target select. Counter and FSM stay in the top module.

Test Plan:
- Syscall at ws_pc=32'hBFC0_1000, bd=0 -> one-cycle wb_ex=1, wb_exccode=8, wb_pc=32'hBFC0_1000. Then pipe_flush for 2 cycles, then redirect_valid with redirect_pc=32'hBFC0_0380. Handshake returns to IDLE.
- AdEL in a delay slot, ws_pc=32'h8000_0104, badvaddr=32'h0000_0003 -> wb_bd=1, wb_BadVaddr=32'h3, wb_exccode=4.
- has_int=1 together with ws_ex (exccode 12) -> wb_exccode=0, with exactly one wb_ex pulse.
- MTC0 EPC=32'h8000_2000, next cycle ERET -> mtc0_we then eret_flush. cp0_addr=8'h70 on the ERET cycle; redirect_pc=32'h8000_2000.
- redirect_ready held low 5 cycles in REDIRECT; ws_valid and has_int toggled meanwhile -> redirect_pc stable, no CP0 strobes, ws_ready=0.
- resetn dropped during FLUSH -> all outputs 0 immediately. After release, a plain commit causes no flush.
